// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared PE definitions: sequencer state encoding and default operand width.
package pe_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pe_state_e;

endpackage

// File: rtl/bit_serial_add_ctrl_fa_slice.sv
// Single-bit full adder slice, time-shared by the serial add sequencer.
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and majority carry of the three inputs.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice plus carry flop,
// operands processed LSB-first over WIDTH cycles.
module bit_serial_add_ctrl
  import pe_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  pe_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, ovf_q;
  logic             fa_s, fa_co;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  serial_fa_slice u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last_bit) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // New result bit enters at the MSB while earlier bits move toward the LSB.
  always_comb begin
    sum_d            = sum_q >> 1;
    sum_d[WIDTH-1]   = fa_s;
  end

  // Operand shifting, carry chain, bit counter and result flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_sh    <= in_a;
          b_sh    <= in_sub ? ~in_b : in_b;
          carry_q <= in_sub;
          cnt_q   <= '0;
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          if (last_bit) begin
            // Sign-bit carry-in vs carry-out disagreeing means signed overflow.
            cout_q <= fa_co;
            ovf_q  <= carry_q ^ fa_co;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against an arithmetic reference.
module tb_bit_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
  logic [7:0] in_a, in_b, out_sum;
  logic       in_valid1, in_ready1, in_sub1, out_valid1, out_ready1, out_cout1, out_ovf1;
  logic [0:0] in_a1, in_b1, out_sum1;

  int vectors    = 0;
  int miscompares = 0;

  bit_serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  bit_serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_op(input int w, input int a, input int b, input bit sub,
                                 output int s, output bit c, output bit v);
    int full, sa, sb, r;
    if (sub) begin
      full = a - b;
      c    = (a >= b);
    end else begin
      full = a + b;
      c    = ((full >> w) & 1) != 0;
    end
    s  = full & ((1 << w) - 1);
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sub ? sa - sb : sa + sb;
    v  = (r < -(1 << (w - 1))) || (r > (1 << (w - 1)) - 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation: accept, latency, result, optional hold and junk requests, consume.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input bit sub,
                         input int hold, input bit junk, input string tag);
    int s, n;
    bit c, v;
    logic [7:0] held;
    ref_op(8, int'(a), int'(b), sub, s, c, v);
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    step();
    in_valid = 1'b0;
    if (junk) begin in_a = 8'($urandom); in_b = 8'($urandom); in_sub = 1'($urandom); end
    check({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      if (junk && n == 2) in_valid = 1'b1;
      step();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd8);
    check({tag, " sum"}, 32'(out_sum), 32'(s));
    check({tag, " cout"}, 32'(out_cout), 32'(c));
    check({tag, " ovf"}, 32'(out_ovf), 32'(v));
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = junk;
      step();
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " hold sum"}, 32'(out_sum), 32'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int s;
    bit c, v;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; out_ready1 = 1'b0;
    #12;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_sum", 32'(out_sum), 32'd0);
    check("reset cout/ovf", 32'({out_cout, out_ovf}), 32'd0);
    check("reset w1 in_ready", 32'(in_ready1), 32'd1);
    rst = 1'b0;
    step();

    // Directed cases, including carry, overflow and borrow boundaries.
    run_op8(8'h05, 8'h03, 1'b0, 0, 1'b0, "5+3");
    run_op8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff+1");
    run_op8(8'h7F, 8'h01, 1'b0, 0, 1'b0, "7f+1");
    run_op8(8'h03, 8'h05, 1'b1, 0, 1'b0, "3-5");
    run_op8(8'h80, 8'h01, 1'b1, 0, 1'b0, "80-1");
    run_op8(8'h5A, 8'h3C, 1'b1, 5, 1'b1, "hold+junk");

    // Reset in the middle of RUN, three bits in.
    in_valid = 1'b1; in_a = 8'hAB; in_b = 8'hCD; in_sub = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    check("midrun rst out_sum", 32'(out_sum), 32'd0);
    #2;
    rst = 1'b0;
    step();
    run_op8(8'h10, 8'h20, 1'b0, 0, 1'b0, "10+20 after rst");

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
              1'($urandom), "rand8");
    end

    // WIDTH=1: back-to-back ops with in_valid and out_ready held high.
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b1; in_sub1 = 1'b0; out_ready1 = 1'b1;
    check("w1 ready before", 32'(in_ready1), 32'd1);
    step();
    check("w1 ready run", 32'(in_ready1), 32'd0);
    check("w1 valid run", 32'(out_valid1), 32'd0);
    step();
    check("w1 valid done", 32'(out_valid1), 32'd1);
    check("w1 ready done", 32'(in_ready1), 32'd0);
    check("w1 1+1 sum", 32'(out_sum1), 32'd0);
    check("w1 1+1 cout", 32'(out_cout1), 32'd1);
    check("w1 1+1 ovf", 32'(out_ovf1), 32'd1);
    step();
    check("w1 ready after", 32'(in_ready1), 32'd1);
    for (int k = 0; k < 12; k++) begin
      in_a1 = 1'($urandom); in_b1 = 1'($urandom); in_sub1 = 1'($urandom);
      ref_op(1, int'(in_a1), int'(in_b1), in_sub1, s, c, v);
      check("w1 rand ready", 32'(in_ready1), 32'd1);
      step();
      check("w1 rand busy", 32'(in_ready1), 32'd0);
      step();
      check("w1 rand valid", 32'(out_valid1), 32'd1);
      check("w1 rand result", 32'({out_sum1, out_cout1, out_ovf1}), 32'({s[0], c, v}));
      step();
    end
    in_valid1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
